// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit FIFO, or a 16550-style 1-deep holding register, feeding uart_tx.
// Define UART_TXF_THRESH_EN to build the registered low-water flag thresh_hit.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun,
    input  logic [$clog2(DEPTH)-1:0]   thresh,
    output logic                       thresh_hit
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             en_q, flush, do_push, do_pop;

    // A mode change flushes on the following cycle, exactly like clr.
    assign flush   = clr | (en != en_q);
    assign empty   = count == '0;
    assign full    = en ? count == CAP : !empty;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push = push & (!full | pop);
    assign do_pop  = pop & !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push && !flush && !rst) mem[wr_ptr] <= din;

    always_ff @(posedge clk) begin
        en_q <= en;
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (push && full && !pop) overrun <= 1'b1;
        end
    end

`ifdef UART_TXF_THRESH_EN
    always_ff @(posedge clk)
        thresh_hit <= rst ? 1'b0 : (count <= {1'b0, thresh});
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign thresh_hit    = 1'b0;
`endif
endmodule
